// File: rtl/addr_mode_sequencer.sv
// Fetch/address/execute timing sequencer: latches the opcode, decodes its addressing
// mode and steps A0..A3 for the flag generators. Optional EXEC timeout: EXEC_TIMEOUT_EN.
module addr_mode_sequencer #(
    parameter int unsigned RST_CYCLES = 7,
    parameter int unsigned MAX_EXEC   = 7
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rdy,
    input  logic [7:0] data_in,
    input  logic       instr_done,
    input  logic       carry_from_low_op,
    output logic [1:0] phase,
    output logic [1:0] addr_state,
    output logic [2:0] exec_state,
    output logic [3:0] mode,
    output logic [7:0] opcode,
    output logic       carry_to_high_op,
    output logic       sync,
    output logic       exec_timeout
);

    typedef enum logic [1:0] {
        PH_RESET = 2'd0,
        PH_FETCH = 2'd1,
        PH_ADDR  = 2'd2,
        PH_EXEC  = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        M_IMM   = 4'd0,
        M_IMPL  = 4'd1,
        M_ZPG   = 4'd2,
        M_ZPG_X = 4'd3,
        M_ZPG_Y = 4'd4,
        M_ABS   = 4'd5,
        M_ABS_X = 4'd6,
        M_ABS_Y = 4'd7,
        M_IND_X = 4'd8,
        M_IND_Y = 4'd9
    } mode_t;

    localparam logic [3:0] LP_RST_LAST  = 4'(RST_CYCLES - 1);
    localparam logic [2:0] LP_EXEC_LAST = 3'(MAX_EXEC - 1);
`ifdef EXEC_TIMEOUT_EN
    localparam bit LP_TIMEOUT_EN = 1'b1;
`else
    localparam bit LP_TIMEOUT_EN = 1'b0;
`endif

    function automatic mode_t decode(input logic [7:0] op);
        mode_t m;
        m = M_IMPL;
        case (op[1:0])
            2'b01: begin
                case (op[4:2])
                    3'd0:    m = M_IND_X;
                    3'd1:    m = M_ZPG;
                    3'd2:    m = M_IMM;
                    3'd3:    m = M_ABS;
                    3'd4:    m = M_IND_Y;
                    3'd5:    m = M_ZPG_X;
                    3'd6:    m = M_ABS_Y;
                    default: m = M_ABS_X;
                endcase
            end
            2'b10: begin
                case (op[4:2])
                    3'd0:    m = M_IMM;
                    3'd1:    m = M_ZPG;
                    3'd3:    m = M_ABS;
                    3'd5:    m = (op[7:5] == 3'd4 || op[7:5] == 3'd5) ? M_ZPG_Y : M_ZPG_X;
                    3'd7:    m = (op[7:5] == 3'd5) ? M_ABS_Y : M_ABS_X;
                    default: m = M_IMPL;
                endcase
            end
            2'b00: begin
                case (op[4:2])
                    3'd0:    m = (op[7:5] >= 3'd5) ? M_IMM : M_IMPL;
                    3'd1:    m = M_ZPG;
                    3'd3:    m = M_ABS;
                    3'd4:    m = M_IMM;
                    3'd5:    m = M_ZPG_X;
                    3'd7:    m = M_ABS_X;
                    default: m = M_IMPL;
                endcase
            end
            default: m = M_IMPL;
        endcase
        // JSR sits in the cc=00/bbb=000 implied slot but carries a 16-bit target
        if (op == 8'h20) m = M_ABS;
        return m;
    endfunction

    function automatic logic [2:0] addr_cycles(input mode_t m);
        logic [2:0] n;
        case (m)
            M_ZPG:                    n = 3'd1;
            M_ZPG_X, M_ZPG_Y, M_ABS:  n = 3'd2;
            M_ABS_X, M_ABS_Y:         n = 3'd3;
            M_IND_X, M_IND_Y:         n = 3'd4;
            default:                  n = 3'd0;
        endcase
        return n;
    endfunction

    phase_t     r_phase;
    mode_t      r_mode;
    logic [3:0] r_rst_cnt;
    logic [7:0] r_opcode;
    logic [1:0] r_addr_state;
    logic [2:0] r_exec_state;
    logic       r_carry;
    logic       r_timeout;

    mode_t      w_dec_mode;
    logic [2:0] w_dec_cycles;
    logic       w_addr_last;

    assign w_dec_mode   = decode(data_in);
    assign w_dec_cycles = addr_cycles(w_dec_mode);
    assign w_addr_last  = ({1'b0, r_addr_state} == (addr_cycles(r_mode) - 3'd1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_phase      <= PH_RESET;
            r_mode       <= M_IMPL;
            r_rst_cnt    <= '0;
            r_opcode     <= 8'hEA;
            r_addr_state <= '0;
            r_exec_state <= '0;
            r_carry      <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (rdy) begin
            r_timeout <= 1'b0;
            case (r_phase)
                PH_RESET: begin
                    r_rst_cnt <= r_rst_cnt + 4'd1;
                    if (r_rst_cnt == LP_RST_LAST) r_phase <= PH_FETCH;
                end
                PH_FETCH: begin
                    r_opcode     <= data_in;
                    r_mode       <= w_dec_mode;
                    r_addr_state <= '0;
                    r_exec_state <= '0;
                    r_phase      <= (w_dec_cycles != 3'd0) ? PH_ADDR : PH_EXEC;
                end
                PH_ADDR: begin
                    if (r_mode == M_IND_Y && r_addr_state == 2'd1) r_carry <= carry_from_low_op;
                    if (w_addr_last) begin
                        r_phase      <= PH_EXEC;
                        r_addr_state <= '0;
                        r_exec_state <= '0;
                    end else begin
                        r_addr_state <= r_addr_state + 2'd1;
                    end
                end
                PH_EXEC: begin
                    if (instr_done) begin
                        r_phase      <= PH_FETCH;
                        r_exec_state <= '0;
                        r_carry      <= 1'b0;
                    end else if (LP_TIMEOUT_EN && r_exec_state == LP_EXEC_LAST) begin
                        r_phase      <= PH_FETCH;
                        r_exec_state <= '0;
                        r_carry      <= 1'b0;
                        r_timeout    <= 1'b1;
                    end else if (r_exec_state != 3'd7) begin
                        r_exec_state <= r_exec_state + 3'd1;
                    end
                end
                default: r_phase <= PH_RESET;
            endcase
        end
    end

    assign phase            = r_phase;
    assign addr_state       = r_addr_state;
    assign exec_state       = r_exec_state;
    assign mode             = r_mode;
    assign opcode           = r_opcode;
    assign carry_to_high_op = r_carry;
    assign sync             = (r_phase == PH_FETCH);
    assign exec_timeout     = r_timeout;

endmodule

// File: doc/addr_mode_sequencer.md
Name: addr_mode_sequencer

Overview:
- Upstream timing stage for the per-mode control-flag generators: ZPG, Absolute, Absolute_X/Y, ZPG_X/Y, Indrect_X/Y.
- Captures the opcode during the fetch cycle and decodes its addressing mode.
- Steps the address-state counter (A0..A3) that drives the flag generators, then holds an execute phase until the execute logic signals completion.
- Registers the IND_Y low-byte carry so the flag generator sees it one state later.

Parameters:
RST_CYCLES, 7, cycles spent in RESET phase after nrst deasserts before first FETCH (legal range 1..15)
MAX_EXEC, 7, execute-cycle limit used by the optional timeout (legal range 1..7)

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
rdy  input  1  advance enable; when 0 all registers hold
data_in  input  8  data bus; holds opcode during FETCH
instr_done  input  1  execute logic: current EXEC cycle is the last
carry_from_low_op  input  1  ALU carry out of the IND_Y low-byte add
phase  output  2  0=RESET, 1=FETCH, 2=ADDR, 3=EXEC
addr_state  output  2  A0..A3 index, valid in ADDR, 0 otherwise
exec_state  output  3  EXEC cycle index, 0 outside EXEC
mode  output  4  0 IMM, 1 IMPL, 2 ZPG, 3 ZPG_X, 4 ZPG_Y, 5 ABS, 6 ABS_X, 7 ABS_Y, 8 IND_X, 9 IND_Y
opcode  output  8  latched opcode
carry_to_high_op  output  1  registered IND_Y carry
sync  output  1  high while phase==FETCH
exec_timeout  output  1  one-cycle pulse on forced EXEC exit (optional feature only)

Behaviour:
- Reset (nrst=0, async): phase=RESET, opcode=8'hEA, mode=IMPL, addr_state=0, exec_state=0, carry_to_high_op=0, exec_timeout=0, reset counter=0.
- Reset released mid-instruction always restarts from RESET.
- rdy=0: every register holds, including the reset counter and carry. Outputs are stable and sync is unchanged.
- RESET: the counter increments on each rdy cycle. On the cycle the counter equals RST_CYCLES-1, next phase is FETCH.
- FETCH (sync=1): on a rdy cycle, opcode<=data_in and mode<=decode(data_in), both registered.
  - Next phase is ADDR (addr_state=0) if the decoded mode has address cycles; otherwise EXEC.
- Decode. Define cc=op[1:0], bbb=op[4:2], aaa=op[7:5].
  - cc=01, bbb=0..7: IND_X, ZPG, IMM, ABS, IND_Y, ZPG_X, ABS_Y, ABS_X.
  - cc=10, bbb=000: IMM.
  - cc=10, bbb=001: ZPG.
  - cc=10, bbb=011: ABS.
  - cc=10, bbb=101: ZPG_Y if aaa in {100,101}, else ZPG_X.
  - cc=10, bbb=111: ABS_Y if aaa=101, else ABS_X.
  - cc=10, other bbb: IMPL.
  - cc=00, bbb=000: IMM if aaa>=101, else IMPL.
  - cc=00, bbb=001: ZPG.
  - cc=00, bbb=011: ABS.
  - cc=00, bbb=100: IMM (branch operand).
  - cc=00, bbb=101: ZPG_X.
  - cc=00, bbb=111: ABS_X.
  - cc=00, other bbb: IMPL.
  - Override: 8'h20 (JSR) = ABS.
  - cc=11: IMPL.
- Address cycle count N by mode:
  - IMM, IMPL: 0
  - ZPG: 1
  - ZPG_X, ZPG_Y, ABS: 2
  - ABS_X, ABS_Y: 3
  - IND_X, IND_Y: 4
- ADDR: addr_state increments on each rdy cycle. When addr_state==N-1, next phase is EXEC with exec_state=0 and addr_state=0.
- IND_Y carry: carry_to_high_op<=carry_from_low_op on the rdy cycle where mode==IND_Y and addr_state==1. The value is held through A2/A3 and cleared on entry to FETCH.
- EXEC: exec_state increments on each rdy cycle, saturating at 7. If instr_done=1 on a rdy cycle, next phase is FETCH and exec_state=0.
  - instr_done outside EXEC is ignored.
- Latency: FETCH to first EXEC cycle is 1+N cycles at rdy=1. Back-to-back IMPL instructions alternate FETCH/EXEC with no bubble.

Optional Feature:
EXEC_TIMEOUT_EN
- Defined: if EXEC has run MAX_EXEC rdy cycles (exec_state==MAX_EXEC-1) with instr_done=0, the next phase is FETCH. exec_timeout pulses high for that one transition cycle.
- Not defined: EXEC waits indefinitely for instr_done and exec_timeout is tied to 0.

Test Plan:
- Reset: hold nrst=0, release with rdy=1 -> phase=RESET for 7 cycles, then sync=1. Opcode reads 8'hEA until the first fetch.
- ZPG load: data_in=8'hA5 in FETCH -> mode=2, one ADDR cycle (addr_state=0), then EXEC. With instr_done on EXEC cycle 0, FETCH returns 3 cycles after the first FETCH.
- IND_Y with stall: opcode 8'hB1, carry_from_low_op=1 in A1, rdy=0 for 2 cycles during A2 -> addr_state holds at 2. carry_to_high_op=1 through A3, and clears at the next FETCH.
- Decode sweep: 8'hB6 -> ZPG_Y, 8'hBE -> ABS_Y, 8'h20 -> ABS, 8'hD0 -> IMM, 8'h0A -> IMPL, 8'hFF -> IMPL. Verify addr cycle counts 2/3/2/0/0/0.
- Async reset asserted mid-ADDR of ABS_X (addr_state=1) -> all outputs take reset values immediately, without waiting for a clk edge.
- EXEC_TIMEOUT_EN defined, instr_done held 0 -> after 7 EXEC cycles, exec_timeout pulses once and phase=FETCH. Without the macro, phase stays EXEC and exec_state saturates at 7.
